if_fetch_stage: RTL and testbench

- Fetch-side responder to the pipeline hazard unit's control outputs (PC_Write, IF_Write, addrSel).
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Carries out stalls, jump/branch redirects and IF/ID flushes.
- Absorbs variable instruction-memory latency so that no redirect is ever lost.

---
 rtl/if_pkg.sv | 20 ++
 rtl/ifid_reg.sv | 44 ++++
 rtl/if_fetch_stage.sv | 176 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_KILL  = 2'd2
  } fetch_state_t;

  localparam logic [1:0] ADDRSEL_SEQ    = 2'b00;
  localparam logic [1:0] ADDRSEL_JUMP   = 2'b01;
  localparam logic [1:0] ADDRSEL_BRANCH = 2'b10;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  function automatic logic is_redirect_sel(input logic [1:0] sel);
    return (sel == ADDRSEL_JUMP) || (sel == ADDRSEL_BRANCH);
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats load, otherwise hold.
module ifid_reg
  import if_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic [31:0]       i_instr,
  input  logic [ADDR_W-1:0] i_pcplus4,
  input  logic              i_valid,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_pcplus4,
  output logic              o_valid
);

  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pcplus4;
  logic              r_valid;

  // A flush kills the instruction but leaves PC+4 as it was.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_instr   <= NOP_INSTR;
      r_pcplus4 <= '0;
      r_valid   <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr   <= i_instr;
      r_pcplus4 <= i_pcplus4;
      r_valid   <= i_valid;
    end
  end

  assign o_instr   = r_instr;
  assign o_pcplus4 = r_pcplus4;
  assign o_valid   = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC, imem handshake, redirect tracking across slow memory, IF/ID.
// Optional perf counters built only when IF_PERF_CNT_EN is defined.
//
// state   | meaning
// S_FETCH | request outstanding at PC
// S_HOLD  | word parked in skid, waiting for the hazard unit to release
// S_KILL  | redirect pending, draining the in-flight request at the old PC
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]       NOP_INSTR    = NOP_INSTR_DEFAULT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              PC_Write,
  input  logic              IF_Write,
  input  logic [1:0]        addrSel,
  input  logic [ADDR_W-1:0] JumpTarget,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] PC,
  output logic [31:0]       IFID_Instr,
  output logic [ADDR_W-1:0] IFID_PCPlus4,
  output logic              IFID_Valid,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_redirect_pc;
  logic [31:0]       r_skid;

  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_redirect_pc_nxt;
  logic [31:0]       w_skid_nxt;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic              w_redirect;
  logic              w_req;
  logic              w_done;
  logic              w_load;
  logic              w_flush;
  logic [31:0]       w_ld_instr;
  logic              w_ld_valid;

  assign w_redirect = PC_Write && is_redirect_sel(addrSel);
  assign w_target   = (addrSel == ADDRSEL_JUMP) ? JumpTarget : BranchTarget;
  assign w_pc_plus4 = r_pc + ADDR_W'(4);
  // Gated by Rst so a stale ready during or right after reset can't complete anything.
  assign w_req      = Rst && (r_state != S_HOLD);
  assign w_done     = w_req && imem_ready;

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_redirect_pc_nxt = r_redirect_pc;
    w_skid_nxt        = r_skid;
    w_load            = 1'b0;
    w_flush           = 1'b0;
    w_ld_instr        = NOP_INSTR;
    w_ld_valid        = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_redirect) begin
          w_flush = 1'b1;
          if (w_done) w_pc_nxt = w_target;
          else begin
            w_redirect_pc_nxt = w_target;
            w_state_nxt       = S_KILL;
          end
        end else if (w_done) begin
          if (IF_Write && PC_Write) begin
            w_load     = 1'b1;
            w_ld_instr = imem_rdata;
            w_ld_valid = 1'b1;
            w_pc_nxt   = w_pc_plus4;
          end else begin
            w_skid_nxt  = imem_rdata;
            w_state_nxt = S_HOLD;
          end
        end else if (IF_Write) begin
          w_load = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_flush     = 1'b1;
          w_pc_nxt    = w_target;
          w_state_nxt = S_FETCH;
        end else if (IF_Write && PC_Write) begin
          w_load      = 1'b1;
          w_ld_instr  = r_skid;
          w_ld_valid  = 1'b1;
          w_pc_nxt    = w_pc_plus4;
          w_state_nxt = S_FETCH;
        end
      end
      S_KILL: begin
        if (w_redirect) w_redirect_pc_nxt = w_target;
        w_flush = w_redirect || IF_Write;
        if (w_done) begin
          w_pc_nxt    = w_redirect ? w_target : r_redirect_pc;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_VECTOR;
      r_redirect_pc <= '0;
      r_skid        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
      r_skid        <= w_skid_nxt;
    end
  end

  ifid_reg #(
    .ADDR_W   (ADDR_W),
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .i_clk    (Clk),
    .i_rst_n  (Rst),
    .i_load   (w_load),
    .i_flush  (w_flush),
    .i_instr  (w_ld_instr),
    .i_pcplus4(w_pc_plus4),
    .i_valid  (w_ld_valid),
    .o_instr  (IFID_Instr),
    .o_pcplus4(IFID_PCPlus4),
    .o_valid  (IFID_Valid)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_stall;

  // Any non-redirect cycle that doesn't deliver a real instruction is a stall.
  assign w_stall = !w_redirect && !(w_load && w_ld_valid);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))    r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_redirect && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign PC        = r_pc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed vectors queue expected post-edge state.
module tb_if_fetch_stage;

  logic        Clk, Rst, PC_Write, IF_Write;
  logic [1:0]  addrSel;
  logic [31:0] JumpTarget, BranchTarget, imem_addr, imem_rdata, PC;
  logic [31:0] IFID_Instr, IFID_PCPlus4, stall_cnt, flush_cnt;
  logic        imem_req, imem_ready, IFID_Valid;

  if_fetch_stage dut (
    .Clk(Clk), .Rst(Rst), .PC_Write(PC_Write), .IF_Write(IF_Write), .addrSel(addrSel),
    .JumpTarget(JumpTarget), .BranchTarget(BranchTarget), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC(PC),
    .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        req;
    logic [31:0] instr;
    logic [31:0] p4;
    bit          chk_p4;
    logic        valid;
    logic [31:0] fc;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_fc = 0;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  function automatic logic [31:0] iw(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic step(input string name, input logic rst, input logic pcw, input logic ifw,
                      input logic [1:0] sel, input logic [31:0] jt, input logic [31:0] bt,
                      input logic rdy, input logic [31:0] rdata,
                      input logic [31:0] e_pc, input logic e_req, input logic [31:0] e_instr,
                      input logic [31:0] e_p4, input bit chk_p4, input logic e_valid);
    exp_t e;
    @(negedge Clk);
    Rst = rst; PC_Write = pcw; IF_Write = ifw; addrSel = sel;
    JumpTarget = jt; BranchTarget = bt; imem_ready = rdy; imem_rdata = rdata;
    if (!rst) exp_fc = 0;
    else if (pcw && (sel == 2'b01 || sel == 2'b10)) exp_fc = exp_fc + 1;
    e.name = name; e.pc = e_pc; e.req = e_req; e.instr = e_instr;
    e.p4 = e_p4; e.chk_p4 = chk_p4; e.valid = e_valid; e.fc = exp_fc;
    q.push_back(e);
  endtask

  // Monitor: compares DUT state shortly after every rising edge that has an expectation queued.
  initial begin
    forever begin
      @(posedge Clk);
      #2;
      if (q.size() > 0) begin : chk
        exp_t e;
        logic ok;
        e = q.pop_front();
        ok = (PC === e.pc) && (imem_addr === e.pc) && (imem_req === e.req) &&
             (IFID_Instr === e.instr) && (IFID_Valid === e.valid) &&
             (!e.chk_p4 || (IFID_PCPlus4 === e.p4));
`ifdef IF_PERF_CNT_EN
        ok = ok && (flush_cnt === e.fc);
`else
        ok = ok && (stall_cnt === 32'd0) && (flush_cnt === 32'd0);
`endif
        vectors++;
        if (!ok) begin
          miscompares++;
          $display("FAIL %s: got pc=%h addr=%h req=%b instr=%h p4=%h v=%b fc=%h sc=%h; want pc=%h req=%b instr=%h p4=%h(chk=%0d) v=%b fc=%h",
                   e.name, PC, imem_addr, imem_req, IFID_Instr, IFID_PCPlus4, IFID_Valid,
                   flush_cnt, stall_cnt, e.pc, e.req, e.instr, e.p4, e.chk_p4, e.valid, e.fc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0; PC_Write = 1'b0; IF_Write = 1'b0; addrSel = 2'b00;
    JumpTarget = '0; BranchTarget = '0; imem_ready = 1'b0; imem_rdata = '0;

    //    name           rst pcw ifw sel jt             bt          rdy rdata          e_pc           req e_instr        e_p4          chk v
    step("rst0",          0, 1, 1, 2'd0, 32'h0,         32'h0,       1, DEAD,          32'h0,         0, NOP,           32'h0,        1, 0);
    step("rst1",          0, 1, 1, 2'd0, 32'h0,         32'h0,       1, DEAD,          32'h0,         0, NOP,           32'h0,        1, 0);
    // zero-wait sequential fetch
    step("seq_00",        1, 1, 1, 2'd0, 32'h0,         32'h0,       1, iw(32'h00),    32'h4,         1, iw(32'h00),    32'h4,        1, 1);
    step("seq_04",        1, 1, 1, 2'd0, 32'h0,         32'h0,       1, iw(32'h04),    32'h8,         1, iw(32'h04),    32'h8,        1, 1);
    step("seq_08",        1, 1, 1, 2'd0, 32'h0,         32'h0,       1, iw(32'h08),    32'hC,         1, iw(32'h08),    32'hC,        1, 1);
    step("seq_0c",        1, 1, 1, 2'd3, 32'h0,         32'h0,       1, iw(32'h0C),    32'h10,        1, iw(32'h0C),    32'h10,       1, 1);
    // memory wait at 0x10
    step("wait_10a",      1, 1, 1, 2'd0, 32'h0,         32'h0,       0, DEAD,          32'h10,        1, NOP,           32'h14,       1, 0);
    step("wait_10b",      1, 1, 1, 2'd0, 32'h0,         32'h0,       0, DEAD,          32'h10,        1, NOP,           32'h14,       1, 0);
    step("wait_10c",      1, 1, 1, 2'd0, 32'h0,         32'h0,       0, DEAD,          32'h10,        1, NOP,           32'h14,       1, 0);
    step("ready_10",      1, 1, 1, 2'd0, 32'h0,         32'h0,       1, iw(32'h10),    32'h14,        1, iw(32'h10),    32'h14,       1, 1);
    // load stall into skid
    step("hold_14a",      1, 0, 0, 2'd0, 32'h0,         32'h0,       1, iw(32'h14),    32'h14,        0, iw(32'h10),    32'h14,       1, 1);
    step("hold_14b",      1, 0, 0, 2'd0, 32'h0,         32'h0,       1, DEAD,          32'h14,        0, iw(32'h10),    32'h14,       1, 1);
    step("release_14",    1, 1, 1, 2'd0, 32'h0,         32'h0,       0, DEAD,          32'h18,        1, iw(32'h14),    32'h18,       1, 1);
    step("seq_18",        1, 1, 1, 2'd0, 32'h0,         32'h0,       1, iw(32'h18),    32'h1C,        1, iw(32'h18),    32'h1C,       1, 1);
    step("seq_1c",        1, 1, 1, 2'd0, 32'h0,         32'h0,       1, iw(32'h1C),    32'h20,        1, iw(32'h1C),    32'h20,       1, 1);
    // jump while waiting, then branch overrides in kill
    step("jump_kill",     1, 1, 0, 2'd1, 32'h400,       32'h0,       0, DEAD,          32'h20,        1, NOP,           32'h0,        0, 0);
    step("kill_wait",     1, 1, 1, 2'd0, 32'h400,       32'h0,       0, DEAD,          32'h20,        1, NOP,           32'h0,        0, 0);
    step("kill_branch",   1, 1, 0, 2'd2, 32'h400,       32'h800,     0, DEAD,          32'h20,        1, NOP,           32'h0,        0, 0);
    step("kill_done",     1, 1, 1, 2'd0, 32'h0,         32'h0,       1, DEAD,          32'h800,       1, NOP,           32'h0,        0, 0);
    step("seq_800",       1, 1, 1, 2'd0, 32'h0,         32'h0,       1, iw(32'h800),   32'h804,       1, iw(32'h800),   32'h804,      1, 1);
    // jump with zero-wait completion drops the word
    step("jump_done",     1, 1, 1, 2'd1, 32'h400,       32'h0,       1, DEAD,          32'h400,       1, NOP,           32'h0,        0, 0);
    step("seq_400",       1, 1, 1, 2'd0, 32'h0,         32'h0,       1, iw(32'h400),   32'h404,       1, iw(32'h400),   32'h404,      1, 1);
    // redirect out of hold discards skid
    step("hold_404",      1, 0, 0, 2'd0, 32'h0,         32'h0,       1, iw(32'h404),   32'h404,       0, iw(32'h400),   32'h404,      1, 1);
    step("hold_branch",   1, 1, 0, 2'd2, 32'h0,         32'h100,     1, DEAD,          32'h100,       1, NOP,           32'h0,        0, 0);
    step("seq_100",       1, 1, 1, 2'd0, 32'h0,         32'h0,       1, iw(32'h100),   32'h104,       1, iw(32'h100),   32'h104,      1, 1);
    // PC+4 wrap
    step("jump_top",      1, 1, 1, 2'd1, 32'hFFFF_FFFC, 32'h0,       1, DEAD,          32'hFFFF_FFFC, 1, NOP,           32'h0,        0, 0);
    step("wrap",          1, 1, 1, 2'd0, 32'h0,         32'h0,       1, 32'h1234_5678, 32'h0,         1, 32'h1234_5678, 32'h0,        1, 1);
    // reset mid-wait with stale ready
    step("seq_00b",       1, 1, 1, 2'd0, 32'h0,         32'h0,       1, iw(32'h00),    32'h4,         1, iw(32'h00),    32'h4,        1, 1);
    step("wait_04",       1, 1, 1, 2'd0, 32'h0,         32'h0,       0, DEAD,          32'h4,         1, NOP,           32'h8,        1, 0);
    step("rst_mid",       0, 1, 1, 2'd0, 32'h0,         32'h0,       1, DEAD,          32'h0,         0, NOP,           32'h0,        1, 0);
    step("rst_stale",     0, 1, 1, 2'd1, 32'h40,        32'h0,       1, DEAD,          32'h0,         0, NOP,           32'h0,        1, 0);
    step("post_rst_wait", 1, 1, 1, 2'd0, 32'h0,         32'h0,       0, DEAD,          32'h0,         1, NOP,           32'h4,        1, 0);
    step("post_rst",      1, 1, 1, 2'd0, 32'h0,         32'h0,       1, iw(32'h00),    32'h4,         1, iw(32'h00),    32'h4,        1, 1);

    repeat (3) @(negedge Clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
